// File: rtl/aes_job_scheduler.sv
// Iterative AES job controller: arbitrates two requesters round-robin and sequences
// the initial AddRoundKey plus Nr rounds through a shared external round unit.
module aes_job_scheduler #(
    parameter int BLK_W = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [3:0]         req_mode,
    input  logic [2*BLK_W-1:0] req_data,
    output logic [1:0]         ks_mode,
    output logic [3:0]         rk_idx,
    input  logic [BLK_W-1:0]   rk,
    output logic [BLK_W-1:0]   rnd_state,
    output logic               rnd_last,
    input  logic [BLK_W-1:0]   rnd_result,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic               resp_err,
    output logic [BLK_W-1:0]   resp_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_r;
    logic [3:0]         rc_r;
    logic               rr_r;
    logic [1:0]         mode_r;
    logic               id_r;
    logic               err_r;
    logic [BLK_W-1:0]   st_r;
    logic               resp_valid_r;
    logic               resp_id_r;
    logic               resp_err_r;
    logic [BLK_W-1:0]   resp_data_r;

    logic [1:0]         grant_s;
    logic [1:0]         req_ready_s;
    logic [1:0]         sel_mode_s;
    logic [BLK_W-1:0]   sel_blk_s;
    logic [3:0]         nr_s;
    logic [3:0]         rk_idx_s;
    logic               rnd_last_s;

    // Round-robin grant; ready is only offered while idle.
    always_comb begin
        grant_s = 2'b00;
        case (req_valid)
            2'b01:   grant_s = 2'b01;
            2'b10:   grant_s = 2'b10;
            2'b11:   grant_s = rr_r ? 2'b10 : 2'b01;
            default: grant_s = 2'b00;
        endcase
        if (state_r == IDLE) begin
            req_ready_s = grant_s;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Mux the winning requester's block and mode.
    always_comb begin
        if (grant_s[1]) begin
            sel_mode_s = req_mode[3:2];
            sel_blk_s  = req_data[2*BLK_W-1:BLK_W];
        end else begin
            sel_mode_s = req_mode[1:0];
            sel_blk_s  = req_data[BLK_W-1:0];
        end
    end

    // Round count of the latched key-size mode.
    always_comb begin
        case (mode_r)
            2'b00:   nr_s = 4'd10;
            2'b01:   nr_s = 4'd12;
            2'b10:   nr_s = 4'd14;
            default: nr_s = 4'd10;
        endcase
    end

    // Round-key index and last-round flag come from state and counter only.
    always_comb begin
        if (state_r == ROUND) begin
            rk_idx_s   = rc_r;
            rnd_last_s = (rc_r == nr_s);
        end else begin
            rk_idx_s   = 4'd0;
            rnd_last_s = 1'b0;
        end
    end

    // Job sequencer and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            rc_r         <= 4'd0;
            rr_r         <= 1'b0;
            mode_r       <= 2'b00;
            id_r         <= 1'b0;
            err_r        <= 1'b0;
            st_r         <= {BLK_W{1'b0}};
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_data_r  <= {BLK_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s != 2'b00) begin
                        id_r    <= grant_s[1];
                        rr_r    <= ~grant_s[1];
                        mode_r  <= sel_mode_s;
                        err_r   <= (sel_mode_s == 2'b11);
                        state_r <= LOAD;
                        if (sel_mode_s != 2'b11) begin
                            st_r <= sel_blk_s;
                        end
                    end
                end
                // Illegal jobs spend their one cycle here without touching the datapath.
                LOAD: begin
                    if (err_r) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b1;
                        resp_id_r    <= id_r;
                        resp_data_r  <= {BLK_W{1'b0}};
                        state_r      <= RESP;
                    end else begin
                        st_r    <= st_r ^ rk;
                        rc_r    <= 4'd1;
                        state_r <= ROUND;
                    end
                end
                ROUND: begin
                    st_r <= rnd_result;
                    if (rc_r == nr_s) begin
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_id_r    <= id_r;
                        resp_data_r  <= rnd_result;
                        state_r      <= RESP;
                    end else begin
                        rc_r <= rc_r + 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_r <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign req_ready  = req_ready_s;
    assign ks_mode    = mode_r;
    assign rk_idx     = rk_idx_s;
    assign rnd_last   = rnd_last_s;
    assign rnd_state  = st_r;
    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_err   = resp_err_r;
    assign resp_data  = resp_data_r;

endmodule

// File: tb/tb_aes_job_scheduler.sv
// Bench for aes_job_scheduler: models the external key-expansion and round units
// with a FIPS-197 key, and scores responses against a reference AES queue.
module tb_aes_job_scheduler;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    typedef struct packed {
        logic         id;
        logic         err;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [3:0]   req_mode;
    logic [255:0] req_data;
    logic [1:0]   ks_mode;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic [127:0] rnd_state;
    logic         rnd_last;
    logic [127:0] rnd_result;
    logic         resp_valid;
    logic         resp_ready;
    logic         resp_id;
    logic         resp_err;
    logic [127:0] resp_data;

    logic [127:0] blk_v [2];
    logic [1:0]   mode_v [2];
    exp_t         sb_q [$];
    int           n_tests = 0;
    int           n_fail = 0;

    logic         obs_id;
    logic         obs_err;
    logic [127:0] obs_data;
    int           obs_lat;
    logic [3:0]   idx_log [16];
    logic         last_log [16];

    always #5 clk = ~clk;

    assign req_data = {blk_v[1], blk_v[0]};
    assign req_mode = {mode_v[1], mode_v[0]};

    aes_job_scheduler #(.BLK_W(128)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_data   (req_data),
        .ks_mode    (ks_mode),
        .rk_idx     (rk_idx),
        .rk         (rk),
        .rnd_state  (rnd_state),
        .rnd_last   (rnd_last),
        .rnd_result (rnd_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_err   (resp_err),
        .resp_data  (resp_data)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from the GF(2^8) inverse (x^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] round_key(input logic [1:0] mode, input logic [3:0] idx);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int          nk;
        if (mode == 2'b11 || idx > 4'd14) return 128'h0;
        nk = 4 + 2 * int'(mode);
        rc = 8'h01;
        for (int i = 0; i < 60; i++) begin
            if (i < nk) begin
                w[i] = KEY[255 - 32 * i -: 32];
            end else begin
                t = w[i - 1];
                if (i % nk == 0) begin
                    t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                    rc = xt(rc);
                end else if (nk == 8 && i % nk == 4) begin
                    t = subword(t);
                end
                w[i] = w[i - nk] ^ t;
            end
        end
        return {w[4 * idx], w[4 * idx + 1], w[4 * idx + 2], w[4 * idx + 3]};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   r [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127 - 8 * i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) r[4 * c + w] = b[4 * ((c + w) % 4) + w];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = r[4 * c]; a1 = r[4 * c + 1]; a2 = r[4 * c + 2]; a3 = r[4 * c + 3];
                r[4 * c]     = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                r[4 * c + 1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                r[4 * c + 2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                r[4 * c + 3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[127 - 8 * i -: 8] = r[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [1:0] mode);
        logic [127:0] s;
        int           nr;
        nr = 10 + 2 * int'(mode);
        s  = pt ^ round_key(mode, 4'd0);
        for (int r = 1; r <= nr; r++) s = aes_round(s, round_key(mode, 4'(r)), r == nr);
        return s;
    endfunction

    function automatic logic [127:0] fips_ct(input logic [1:0] mode);
        case (mode)
            2'b00:   return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            2'b01:   return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
            default: return 128'h8ea2b7ca516745bfeafc49904b496089;
        endcase
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Behavioural key-expansion and round units shared by the scheduler.
    assign rk         = round_key(ks_mode, rk_idx);
    assign rnd_result = aes_round(rnd_state, rk, rnd_last);

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
    endtask

    // Issue one job, push its expectation, and wait (bounded) for resp_valid.
    task automatic run_job(input int id, input logic [1:0] mode, input logic [127:0] blk);
        bit   granted;
        exp_t e;
        granted    = 1'b0;
        obs_lat    = -1;
        blk_v[id]  = blk;
        mode_v[id] = mode;
        req_valid  = 2'b00;
        req_valid[id] = 1'b1;
        for (int t = 0; t < 20 && !granted; t++) begin
            #1;
            if (req_ready[id]) granted = 1'b1;
            @(negedge clk);
        end
        req_valid = 2'b00;
        if (granted) begin
            e.id   = id[0];
            e.err  = (mode == 2'b11);
            e.data = e.err ? 128'h0 : aes_ref(blk, mode);
            sb_q.push_back(e);
            for (int j = 0; j < 40; j++) begin
                if (j < 16) begin
                    idx_log[j]  = rk_idx;
                    last_log[j] = rnd_last;
                end
                if (resp_valid) begin
                    obs_lat = j;
                    break;
                end
                @(negedge clk);
            end
        end
        obs_id   = resp_id;
        obs_err  = resp_err;
        obs_data = resp_data;
    endtask

    task automatic accept_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            blk_v[i]  = 128'h0;
            mode_v[i] = 2'b00;
        end
        repeat (2) @(negedge clk);
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_tests++; if ({resp_id, resp_err} !== 2'b00) begin n_fail++; $display("FAIL reset_resp_id_err: got %b want 00", {resp_id, resp_err}); end
        n_tests++; if (resp_data !== 128'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
        n_tests++; if (rnd_state !== 128'h0) begin n_fail++; $display("FAIL reset_rnd_state: got %h want 0", rnd_state); end
        n_tests++; if ({rk_idx, rnd_last} !== 5'b00000) begin n_fail++; $display("FAIL reset_rk_idx_last: got %b want 00000", {rk_idx, rnd_last}); end
        n_tests++; if (ks_mode !== 2'b00) begin n_fail++; $display("FAIL reset_ks_mode: got %b want 00", ks_mode); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips();
        exp_t e;
        int   nr;
        for (int m = 0; m < 3; m++) begin
            nr = 10 + 2 * m;
            run_job(0, 2'(m), PT);
            e = sb_q.size() > 0 ? sb_q.pop_front() : '0;
            n_tests++; if (obs_lat != nr + 1) begin n_fail++; $display("FAIL fips_latency m%0d: got %0d want %0d", m, obs_lat, nr + 1); end
            n_tests++; if (obs_data !== fips_ct(2'(m))) begin n_fail++; $display("FAIL fips_data m%0d: got %h want %h", m, obs_data, fips_ct(2'(m))); end
            n_tests++; if (obs_data !== e.data) begin n_fail++; $display("FAIL fips_sb_data m%0d: got %h want %h", m, obs_data, e.data); end
            n_tests++; if ({obs_id, obs_err} !== 2'b00) begin n_fail++; $display("FAIL fips_id_err m%0d: got %b want 00", m, {obs_id, obs_err}); end
            n_tests++; if (ks_mode !== 2'(m)) begin n_fail++; $display("FAIL fips_ks_mode m%0d: got %b want %0d", m, ks_mode, m); end
            for (int j = 0; j <= nr; j++) begin
                n_tests++; if (idx_log[j] !== 4'(j)) begin n_fail++; $display("FAIL fips_rk_idx m%0d j%0d: got %0d want %0d", m, j, idx_log[j], j); end
                n_tests++; if (last_log[j] !== (j == nr)) begin n_fail++; $display("FAIL fips_rnd_last m%0d j%0d: got %b want %b", m, j, last_log[j], j == nr); end
            end
            accept_resp();
        end
    endtask

    task automatic test_illegal();
        exp_t e;
        run_job(1, 2'b11, rand128());
        e = sb_q.size() > 0 ? sb_q.pop_front() : '0;
        n_tests++; if (obs_lat != 1) begin n_fail++; $display("FAIL illegal_latency: got %0d want 1", obs_lat); end
        n_tests++; if ({obs_id, obs_err} !== {e.id, e.err}) begin n_fail++; $display("FAIL illegal_id_err: got %b want %b", {obs_id, obs_err}, {e.id, e.err}); end
        n_tests++; if (obs_data !== 128'h0) begin n_fail++; $display("FAIL illegal_data: got %h want 0", obs_data); end
        n_tests++; if ({idx_log[0], idx_log[1], rk_idx} !== 12'h000) begin n_fail++; $display("FAIL illegal_rk_idx: got %h want 000", {idx_log[0], idx_log[1], rk_idx}); end
        accept_resp();
    endtask

    task automatic test_hold();
        exp_t e;
        run_job(0, 2'b01, rand128());
        e = sb_q.size() > 0 ? sb_q.pop_front() : '0;
        n_tests++; if (obs_data !== e.data) begin n_fail++; $display("FAIL hold_data: got %h want %h", obs_data, e.data); end
        mode_v[0] = 2'b00;
        mode_v[1] = 2'b00;
        req_valid = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++; if (resp_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid c%0d: got %b want 1", k, resp_valid); end
            n_tests++; if ({resp_id, resp_err, resp_data} !== {e.id, e.err, e.data}) begin n_fail++; $display("FAIL hold_fields c%0d: got %b %b %h want %b %b %h", k, resp_id, resp_err, resp_data, e.id, e.err, e.data); end
            n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_req_ready c%0d: got %b want 00", k, req_ready); end
        end
        accept_resp();
        // Requester 0 was granted last, so requester 1 wins the tie now.
        n_tests++; if ({resp_valid, req_ready} !== 3'b010) begin n_fail++; $display("FAIL hold_release: got %b want 010", {resp_valid, req_ready}); end
        req_valid = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   got;
        int   pend;
        logic exp_g;
        logic gid;
        do_reset();
        got   = 0;
        pend  = -1;
        exp_g = 1'b0;
        for (int i = 0; i < 2; i++) begin
            blk_v[i]  = rand128();
            mode_v[i] = 2'($urandom_range(0, 2));
        end
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        for (int c = 0; c < 300 && got < 6; c++) begin
            if (pend >= 0) begin
                blk_v[pend]  = rand128();
                mode_v[pend] = 2'($urandom_range(0, 2));
                pend = -1;
            end
            #1;
            if (resp_valid) begin
                if (sb_q.size() == 0) begin
                    n_tests++; n_fail++; $display("FAIL b2b_unexpected: got response id %b want none", resp_id);
                end else begin
                    e = sb_q.pop_front();
                    n_tests++; if (resp_id !== e.id) begin n_fail++; $display("FAIL b2b_resp_id: got %b want %b", resp_id, e.id); end
                    n_tests++; if (resp_data !== e.data) begin n_fail++; $display("FAIL b2b_resp_data: got %h want %h", resp_data, e.data); end
                end
                got++;
            end
            if (req_ready != 2'b00) begin
                gid = req_ready[1];
                n_tests++; if (req_ready !== (exp_g ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_grant: got %b want id %b", req_ready, exp_g); end
                e.id   = gid;
                e.err  = 1'b0;
                e.data = aes_ref(blk_v[gid], mode_v[gid]);
                sb_q.push_back(e);
                pend  = gid ? 1 : 0;
                exp_g = ~exp_g;
            end
            @(negedge clk);
        end
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        n_tests++; if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   granted;
        bit   reached;
        bit   seen;
        do_reset();
        granted   = 1'b0;
        reached   = 1'b0;
        seen      = 1'b0;
        blk_v[0]  = rand128();
        mode_v[0] = 2'b10;
        req_valid = 2'b01;
        for (int t = 0; t < 20 && !granted; t++) begin
            #1;
            if (req_ready[0]) granted = 1'b1;
            @(negedge clk);
        end
        req_valid = 2'b00;
        for (int t = 0; t < 30; t++) begin
            if (rk_idx == 4'd6) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++; if (!reached) begin n_fail++; $display("FAIL mid_reach_rc6: got rk_idx %0d want 6", rk_idx); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if ({req_ready, resp_valid, resp_id, resp_err, rnd_last, rk_idx, ks_mode} !== 12'h000) begin
            n_fail++; $display("FAIL mid_reset_ctrl: got %h want 000", {req_ready, resp_valid, resp_id, resp_err, rnd_last, rk_idx, ks_mode});
        end
        n_tests++; if ({rnd_state, resp_data} !== 256'h0) begin n_fail++; $display("FAIL mid_reset_data: got %h %h want 0", rnd_state, resp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        n_tests++; if (seen) begin n_fail++; $display("FAIL mid_dropped: got resp_valid 1 want 0"); end
        run_job(1, 2'b00, rand128());
        e = sb_q.size() > 0 ? sb_q.pop_front() : '0;
        n_tests++; if (obs_lat != 11) begin n_fail++; $display("FAIL mid_next_latency: got %0d want 11", obs_lat); end
        n_tests++; if ({obs_id, obs_err, obs_data} !== {e.id, e.err, e.data}) begin n_fail++; $display("FAIL mid_next_resp: got %b %b %h want %b %b %h", obs_id, obs_err, obs_data, e.id, e.err, e.data); end
        accept_resp();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fips();
        test_illegal();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
